elevator_car_ctrl: RTL

- Sequential car controller for the 5-floor elevator.
- Latches floor call buttons and moves the car one floor at a time with a fixed travel time. Holds the door open for a fixed time at each requested stop.
- Drives the 4-bit position code {A,B,C,D}. The existing floor decoder consumes this code to produce the one-hot floor indicators, so this block is the encoder/producer side of that interface.

---
 rtl/elevator_car_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: 5-floor car controller producing the {A,B,C,D} position code
module elevator_car_ctrl #(
    parameter int MOVE_TICKS = 4,
    parameter int DOOR_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] call,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic [4:0] pending,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open
);
    localparam logic [1:0] IDLE = 2'd0, MOVE_UP = 2'd1, MOVE_DN = 2'd2, DOOR = 2'd3;
    localparam int CW = $clog2((MOVE_TICKS > DOOR_TICKS ? MOVE_TICKS : DOOR_TICKS) + 1);
    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
    logic [1:0] state, state_n;
    logic [2:0] cur, cur_n;
    logic [3:0] code, code_n;
    logic [CW-1:0] cnt, cnt_n;
    logic pref_up, pref_up_n;
    logic [4:0] served, cur_bit, above_mask;
    logic above, below;
    assign cur_bit = 5'b00001 << cur;
    assign above_mask = 5'b11110 << cur;
    assign above = |(pending & above_mask);
    assign below = |(pending & ~above_mask & ~cur_bit);
    // Decisions use the registered pending only; raw call is seen solely for door restart.
    always_comb begin
        state_n = state;
        cur_n = cur;
        cnt_n = cnt + 1'b1;
        pref_up_n = pref_up;
        served = '0;
        if (state == IDLE) begin
            cnt_n = '0;
            if (pending[cur]) begin
                state_n = DOOR;
                served = cur_bit;
            end else if (above && (pref_up || !below)) begin
                state_n = MOVE_UP;
                pref_up_n = 1'b1;
            end else if (below) begin
                state_n = MOVE_DN;
                pref_up_n = 1'b0;
            end
        end else if (state == DOOR) begin
            if (call[cur]) begin
                cnt_n = '0;
                served = cur_bit;
            end else if (cnt == DOOR_LAST) begin
                state_n = IDLE;
                cnt_n = '0;
            end
        end else if (cnt == MOVE_LAST) begin
            cnt_n = '0;
            cur_n = state == MOVE_UP ? cur + 3'd1 : cur - 3'd1;
            if (pending[cur_n]) begin
                state_n = DOOR;
                served = 5'b00001 << cur_n;
            end
        end
    end
    always_comb
        code_n = cur_n == 3'd1 ? 4'b0001 :
                 cur_n == 3'd2 ? 4'b0011 :
                 cur_n == 3'd3 ? 4'b0100 :
                 cur_n == 3'd4 ? 4'b0101 : 4'b0000;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cur <= '0;
            code <= '0;
            cnt <= '0;
            pref_up <= 1'b1;
            pending <= '0;
        end else begin
            state <= state_n;
            cur <= cur_n;
            code <= code_n;
            cnt <= cnt_n;
            pref_up <= pref_up_n;
            pending <= (pending | call) & ~served;
        end
    end
    assign {A, B, C, D} = code;
    assign moving_up = state == MOVE_UP;
    assign moving_down = state == MOVE_DN;
    assign door_open = state == DOOR;
endmodule
